serial_adder_ctrl: RTL
======================

Name: serial_adder_ctrl

Overview:
Bit-serial adder built around a single combinational 1-bit full-adder cell. It takes WIDTH-bit operands, feeds them LSB-first through the cell, and holds the carry in a flip-flop between bits. It assembles the sum in a shift register over WIDTH cycles. It is the sequential stage directly upstream of the full-adder cell and the consumer of its sum/carry outputs.

Parameters:
WIDTH, 8, operand/sum width in bits (>= 2)
CW, $clog2(WIDTH+1), bit-counter width (derived, localparam)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  request a new addition; sampled in IDLE or DONE only
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
cin  input  1  carry-in, captured on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when the result is updated
sum  output  WIDTH  registered result, held until the next completion
cout  output  1  carry out of bit WIDTH-1, held with sum
ovf  output  1  signed overflow (carry into MSB XOR cout), held with sum

Behaviour:
- Reset (async, rst=1): state=IDLE; operand shift regs, sum shift reg, counter=0; carry FF=0; busy=0, done=0, sum=0, cout=0, ovf=0. Takes effect immediately, including mid-RUN; the partial operation is discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 at an edge -> load a, b; carry FF <- cin; counter <- 0; go to RUN.
  - RUN: each edge computes one bit through the cell using operand LSBs and the carry FF.
    - Sum bit shifts into the MSB of the sum shift reg (right shift).
    - Operand regs shift right; carry FF <- cell carry; counter++.
    - On bit WIDTH-1, also capture the carry FF value as the MSB carry-in (for ovf).
    - When counter reaches WIDTH-1 at an edge: that same edge copies the completed shift reg to sum, the cell carry to cout, and (MSB carry-in XOR cell carry) to ovf; go to DONE.
  - DONE: done=1 for exactly this cycle. Next edge: start=1 -> behave as IDLE accept (back-to-back allowed); else -> IDLE.
- busy=1 exactly in RUN, for WIDTH cycles. start while busy is ignored, and operand changes during RUN have no effect.
- Latency: start sampled at edge k -> done high in the cycle after edge k+WIDTH. Throughput is one result per WIDTH+1 cycles.
- sum/cout/ovf change only on the completing edge or on reset. They never show partial results.
- Arithmetic: unsigned modulo 2^WIDTH with cout. ovf applies the two's-complement interpretation.
- The counter does not wrap within an operation; it is reloaded to 0 on each accept.

Decomposition:
- Shared package: FSM state enum (IDLE/RUN/DONE, 2-bit encoding) and the default WIDTH constant.
- One sub-module: serial_fa_bit, a purely combinational 1-bit full adder (inputs a, b, c; outputs s, co), instantiated once. The FSM, counter and shift registers stay in serial_adder_ctrl.

Test Plan:
- WIDTH=8, a=0x35, b=0x4A, cin=0, start 1 cycle -> busy high 8 cycles; done pulse at edge k+8; sum=0x7F, cout=0, ovf=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1.
- a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0. Then a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1, ovf=1.
- Start 0x10+0x20, then pulse start with 0xFF+0xFF at cycle 3 of RUN -> second start ignored; result 0x30. Start held high through DONE -> new op accepted immediately, busy reasserts the next cycle.
- Mid-RUN (cycle 4) assert rst asynchronously between edges -> outputs drop to 0 immediately; after release a fresh op 0x01+0x02 yields 0x03 with correct latency.
- Exhaustive at WIDTH=4: all a, b, cin -> {cout,sum}==a+b+cin and ovf matches the signed check; done count equals start count.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types for the bit-serial adder: controller state encoding and default width.
package serial_adder_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_fa_bit.sv
// Combinational 1-bit full adder cell used by the bit-serial adder.
module serial_fa_bit (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: feeds operands LSB-first through one full-adder cell,
// keeps the carry in a flip-flop and assembles the sum in a right-shifting register.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic             fa_s, fa_co;

  serial_fa_bit u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .c  (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d   = {fa_s, acc_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_co;
        cnt_d   = cnt_q + CW'(1);
        // On the MSB the carry FF holds the carry into the MSB, so ovf needs no extra register.
        if (cnt_q == LAST_BIT) begin
          sum_d   = acc_d;
          cout_d  = fa_co;
          ovf_d   = carry_q ^ fa_co;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
